key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan.sv | 195 +++++++++++++++++++
 tb/tb_key_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
// key_scan: 4x4 matrix keypad scanner with sweep-level debounce.
//
// Drives one keypad column low at a time, rotating every SCAN_DIV clocks,
// samples the (synchronized) row lines into a 16-bit snapshot and, once per
// full sweep, classifies the snapshot as no key / one key / several keys.
// A key press is accepted after DEBOUNCE consecutive sweeps showing the same
// single key; it is considered released after DEBOUNCE consecutive empty
// sweeps.
//
// Ports:
//   clk      - single clock, all flops on rising edge
//   rst_n    - asynchronous active-low reset
//   KEY_ROW  - row inputs, active low, asynchronous to clk
//   KEY_COL  - column drive, active low, exactly one bit low
//   Scan     - index of the column currently driven low
//   Hex      - code of last accepted key, {row index, column index}
//   valid    - one-cycle pulse on acceptance of a new key press
//   pressed  - high while the accepted key is considered held
module key_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] KEY_ROW,
    output logic [3:0] KEY_COL,
    output logic [1:0] Scan,
    output logic [3:0] Hex,
    output logic       valid,
    output logic       pressed
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [15:0] div_cnt;
    logic        tick;
    logic        sweep_done;
    logic [15:0] snap;
    logic [15:0] snap_full;
    logic [4:0]  ones;
    logic [3:0]  cls_code;
    logic        cls_none;
    logic        cls_single;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  cand;
    logic [3:0]  cnt_inc;

    // Row synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= KEY_ROW;
            row_sync <= row_meta;
        end
    end

    // Column divider
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            Scan    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            Scan    <= Scan + 2'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    assign KEY_COL    = ~(4'b0001 << Scan);
    assign sweep_done = tick && (Scan == 2'd3);

    // Snapshot with the current column's rows merged in. On the last column
    // this is the complete sweep, so classification sees the fresh column 3
    // bits in the same cycle they are captured.
    always_comb begin
        snap_full = snap;
        for (int unsigned r = 0; r < 4; r++) begin
            snap_full[{2'(r), Scan}] = ~row_sync[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (tick) begin
            snap <= snap_full;
        end
    end

    // Sweep classification: none / single (with its code) / multi
    always_comb begin
        ones     = '0;
        cls_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                ones     = ones + 5'd1;
                cls_code = 4'(i);
            end
        end
    end

    assign cls_none   = (ones == 5'd0);
    assign cls_single = (ones == 5'd1);
    assign cnt_inc    = cnt + 4'd1;

    // Debounce FSM, advanced only on sweep completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cand    <= '0;
            Hex     <= '0;
            valid   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (sweep_done) begin
                case (state)
                    ST_IDLE: begin
                        if (cls_single) begin
                            cand <= cls_code;
                            if (DEB == 4'd1) begin
                                state   <= ST_HELD;
                                cnt     <= '0;
                                Hex     <= cls_code;
                                valid   <= 1'b1;
                                pressed <= 1'b1;
                            end else begin
                                state <= ST_CONFIRM;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (cls_single && (cls_code == cand)) begin
                            if (cnt_inc == DEB) begin
                                state   <= ST_HELD;
                                cnt     <= '0;
                                Hex     <= cand;
                                valid   <= 1'b1;
                                pressed <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (cls_none) begin
                            if (DEB == 4'd1) begin
                                state   <= ST_IDLE;
                                cnt     <= '0;
                                pressed <= 1'b0;
                            end else begin
                                state <= ST_RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    default: begin // ST_RELEASE
                        if (cls_none) begin
                            if (cnt_inc == DEB) begin
                                state   <= ST_IDLE;
                                cnt     <= '0;
                                pressed <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: self-checking bench for key_scan (SCAN_DIV=4, DEBOUNCE=2).
// A keypad model turns a 16-bit "keys held" word into row levels from the
// DUT's column drive. Keys change only at sweep boundaries, so every sweep
// sees one consistent key set; a sweep-level reference model predicts
// valid/pressed/Hex after each sweep.
module tb_key_scan;

    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int SWEEP = 4 * SD;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [1:0] scan;
    logic [3:0] hex;
    logic       valid;
    logic       pressed;
    logic [15:0] keys;

    int checks;
    int errors;

    key_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .KEY_ROW (key_row),
        .KEY_COL (key_col),
        .Scan    (scan),
        .Hex     (hex),
        .valid   (valid),
        .pressed (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: row r pulled low when key {r,c} is held and column c is driven low
    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_col[c] && keys[r*4+c]) key_row[r] = 1'b0;
    end

    // Reference model: streak counting over whole sweeps
    bit m_held;
    int m_streak;
    int m_cand;
    int m_hex;
    bit m_pressed;
    bit m_valid;

    function automatic void model_reset();
        m_held = 0; m_streak = 0; m_cand = 0; m_hex = 0; m_pressed = 0; m_valid = 0;
    endfunction

    function automatic void model_sweep(input logic [15:0] k);
        int n;
        int idx;
        n = $countones(k);
        idx = 0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        m_valid = 0;
        if (!m_held) begin
            if (n == 1 && m_streak > 0 && idx == m_cand) m_streak++;
            else if (n == 1 && m_streak == 0) begin m_cand = idx; m_streak = 1; end
            else m_streak = 0;
            if (m_streak == DEB) begin
                m_held = 1; m_streak = 0; m_hex = m_cand; m_pressed = 1; m_valid = 1;
            end
        end else begin
            if (n == 0) m_streak++;
            else m_streak = 0;
            if (m_streak == DEB) begin
                m_held = 0; m_streak = 0; m_pressed = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full sweep with keys k; checks column rotation every cycle and
    // that outputs stay put (valid low) until the sweep-completing edge.
    task automatic do_sweep(input logic [15:0] k);
        int bad;
        int exp_scan;
        bad = 0;
        keys = k;
        for (int i = 1; i <= SWEEP; i++) begin
            @(posedge clk);
            #1;
            exp_scan = (i / SD) % 4;
            if (scan !== 2'(exp_scan)) bad++;
            if (key_col !== ~(4'b0001 << exp_scan)) bad++;
            if (i < SWEEP) begin
                if (valid !== 1'b0) bad++;
                if (pressed !== m_pressed) bad++;
                if (hex !== 4'(m_hex)) bad++;
            end
        end
        chk("sweep_stable", bad, 0);
        model_sweep(k);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_scan", int'(scan), 0);
        chk("rst_col", int'(key_col), 4'b1110);
        chk("rst_valid", int'(valid), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_hex", int'(hex), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] k;
        logic        v;
        logic        p;
        logic [3:0]  h;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [15:0] k, input logic v, input logic p,
                                input logic [3:0] h);
        vec_t e;
        e.k = k; e.v = v; e.p = p; e.h = h;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [15:0] rk;
        int sel;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        keys   = '0;
        model_reset();
        #2;
        apply_reset();

        // Directed sequences: idle, short press, accepted press with hold,
        // bounce during release, two-key chord, multi while held, key change
        add(16'h0000, 0, 0, 4'h0);
        add(16'h0200, 0, 0, 4'h0);
        add(16'h0000, 0, 0, 4'h0);
        add(16'h0200, 0, 0, 4'h0);
        add(16'h0200, 1, 1, 4'h9);
        for (int i = 0; i < 10; i++) add(16'h0200, 0, 1, 4'h9);
        add(16'h0000, 0, 1, 4'h9);
        add(16'h0200, 0, 1, 4'h9);
        add(16'h0000, 0, 1, 4'h9);
        add(16'h0000, 0, 0, 4'h9);
        add(16'h0080, 0, 0, 4'h9);
        add(16'h0080, 1, 1, 4'h7);
        add(16'h0000, 0, 1, 4'h7);
        add(16'h0000, 0, 0, 4'h7);
        for (int i = 0; i < 5; i++) add(16'h4001, 0, 0, 4'h7);
        add(16'h0000, 0, 0, 4'h7);
        add(16'h0080, 0, 0, 4'h7);
        add(16'h0080, 1, 1, 4'h7);
        add(16'h4081, 0, 1, 4'h7);
        add(16'h0000, 0, 1, 4'h7);
        add(16'h0001, 0, 1, 4'h7);
        add(16'h0000, 0, 1, 4'h7);
        add(16'h0000, 0, 0, 4'h7);
        add(16'h0001, 0, 0, 4'h7);
        add(16'h0002, 0, 0, 4'h7);
        add(16'h0002, 0, 0, 4'h7);
        add(16'h0002, 1, 1, 4'h1);
        add(16'h0000, 0, 1, 4'h1);
        add(16'h0000, 0, 0, 4'h1);

        foreach (tbl[i]) begin
            do_sweep(tbl[i].k);
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d_pressed", i), int'(pressed), int'(tbl[i].p));
            chk($sformatf("tbl%0d_hex", i), int'(hex), int'(tbl[i].h));
        end

        // Randomized sweeps against the reference model
        rk = '0;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) rk = rk;
            else if (sel < 7) rk = '0;
            else if (sel < 9) rk = 16'(1) << $urandom_range(0, 15);
            else rk = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            do_sweep(rk);
            chk("rnd_valid", int'(valid), int'(m_valid));
            chk("rnd_pressed", int'(pressed), int'(m_pressed));
            chk("rnd_hex", int'(hex), m_hex);
        end

        // Reset while a key is held discards all history
        repeat (3) do_sweep(16'h0000);
        do_sweep(16'h0200);
        do_sweep(16'h0200);
        chk("pre_rst_valid", int'(valid), 1);
        chk("pre_rst_pressed", int'(pressed), 1);
        apply_reset();
        do_sweep(16'h0200);
        chk("post_rst1_valid", int'(valid), 0);
        chk("post_rst1_pressed", int'(pressed), 0);
        chk("post_rst1_hex", int'(hex), 0);
        do_sweep(16'h0200);
        chk("post_rst2_valid", int'(valid), 1);
        chk("post_rst2_pressed", int'(pressed), 1);
        chk("post_rst2_hex", int'(hex), 9);
        @(posedge clk);
        #1;
        chk("post_rst_valid_clear", int'(valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
